tt_um_bcd_counter_mux: RTL and testbench

Parametrised multi-digit decimal counter with a time-multiplexed 7-segment display driver, built as a Tiny Tapeout user tile. It counts up or down at a rate chosen on the input switches, with pause and clear. It drives one shared segment bus plus one-hot digit enables on the bidirectional pins. It is the next generation of the single-digit seconds counter: N digits, direction control, overflow flag and display scanning.

---
 rtl/tt_um_bcd_counter_mux.sv | 155 +++++++++++++++
 tb/tb_tt_um_bcd_counter_mux.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_bcd_counter_mux.sv
// Multi-digit BCD up/down counter with rate select, pause, clear, sticky
// overflow and a time-multiplexed 7-segment digit scanner.
module tt_um_bcd_counter_mux #(
    parameter int          DIGITS       = 4,
    parameter logic [23:0] TICK_DEFAULT = 24'd10_000_000,
    parameter logic [15:0] SCAN_DIV     = 16'd10_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int          DW      = DIGITS * 4;
    localparam logic [15:0] S_LAST  = SCAN_DIV - 16'd1;
    localparam logic [2:0]  K_LAST  = 3'(DIGITS - 1);
    localparam logic [7:0]  OE_MASK = 8'((9'd1 << DIGITS) - 9'd1);

    logic [4:0]  rate_code;
    logic        down;
    logic        pause;
    logic        clr;
    logic [23:0] cmp_val;

    logic [23:0]   p_q, p_d;
    logic [DW-1:0] dig_q, dig_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   s_q, s_d;
    logic [2:0]    k_q, k_d;

    logic [DW-1:0] dig_step;
    logic          wrap;
    logic [3:0]    cur_dig;
    logic [6:0]    seg;
    logic          unused_ok;

    assign rate_code = ui_in[7:3];
    assign down      = ui_in[2];
    assign pause     = ui_in[1];
    assign clr       = ui_in[0];
    assign unused_ok = &{1'b0, uio_in};

    assign cmp_val = (rate_code == 5'd0) ? TICK_DEFAULT
                                         : {7'd0, rate_code, 12'd0};

    // Whole-number increment/decrement; carry ripples through every digit
    always_comb begin : step_p
        logic [3:0] d;
        logic       c;
        c        = 1'b1;
        d        = 4'd0;
        dig_step = dig_q;
        for (int i = 0; i < DIGITS; i++) begin
            d = dig_q[i*4 +: 4];
            if (c) begin
                if (!down) begin
                    if (d >= 4'd9) begin
                        d = 4'd0;
                    end else begin
                        d = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = 4'd9;
                    end else begin
                        d = (d > 4'd9) ? 4'd8 : d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
            dig_step[i*4 +: 4] = d;
        end
        wrap = c;
    end

    always_comb begin
        p_d   = p_q;
        dig_d = dig_q;
        ovf_d = ovf_q;
        if (clr) begin
            p_d   = '0;
            dig_d = '0;
            ovf_d = 1'b0;
        end else if (ena && !pause) begin
            // >= so a lowered compare value ticks at once instead of wrapping
            if (p_q >= cmp_val) begin
                p_d   = '0;
                dig_d = dig_step;
                ovf_d = ovf_q | wrap;
            end else begin
                p_d = p_q + 24'd1;
            end
        end
    end

    always_comb begin
        s_d = s_q + 16'd1;
        k_d = k_q;
        if (s_q >= S_LAST) begin
            s_d = '0;
            k_d = (k_q >= K_LAST) ? 3'd0 : k_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            dig_q <= '0;
            ovf_q <= 1'b0;
            s_q   <= '0;
            k_q   <= '0;
        end else begin
            p_q   <= p_d;
            dig_q <= dig_d;
            ovf_q <= ovf_d;
            s_q   <= s_d;
            k_q   <= k_d;
        end
    end

    always_comb begin
        cur_dig = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k_q == 3'(i)) begin
                cur_dig = dig_q[i*4 +: 4];
            end
        end
    end

    always_comb begin
        case (cur_dig)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

    assign uo_out  = {ovf_q, seg};
    assign uio_out = 8'd1 << k_q;
    assign uio_oe  = OE_MASK;

endmodule

// File: tb/tb_tt_um_bcd_counter_mux.sv
// Scoreboard bench for tt_um_bcd_counter_mux: expected display frames are
// queued with each stimulus step and compared against a decoded scan frame.
module tb_tt_um_bcd_counter_mux;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic [4:0] rate = 5'd0;
    logic       down = 1'b0;
    logic       pause = 1'b1;
    logic       clr = 1'b0;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    logic [7:0] uo_out2, uio_out2, uio_oe2;

    assign ui_in = {rate, down, pause, clr};

    always #5 clk = ~clk;

    tt_um_bcd_counter_mux #(
        .DIGITS(4), .TICK_DEFAULT(24'd9), .SCAN_DIV(16'd4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out),
        .uio_oe(uio_oe)
    );

    // Two-digit copy so an up-count overflow is reachable in few cycles
    tt_um_bcd_counter_mux #(
        .DIGITS(2), .TICK_DEFAULT(24'd9), .SCAN_DIV(16'd4)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out2), .uio_out(uio_out2),
        .uio_oe(uio_oe2)
    );

    typedef struct {
        int    which;
        int    val;
        bit    ovf;
        string name;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         failures = 0;
    logic [6:0] seg_seen[8];

    function automatic int seg2dig(logic [6:0] s);
        case (s)
            7'h3F: return 0;
            7'h06: return 1;
            7'h5B: return 2;
            7'h4F: return 3;
            7'h66: return 4;
            7'h6D: return 5;
            7'h7D: return 6;
            7'h07: return 7;
            7'h7F: return 8;
            7'h6F: return 9;
            default: return -1;
        endcase
    endfunction

    task automatic push_exp(input int which, input int val,
                            input bit ovf, input string name);
        exp_t e;
        e.which = which;
        e.val   = val;
        e.ovf   = ovf;
        e.name  = name;
        sbq.push_back(e);
    endtask

    task automatic run(input int n);
        pause = 1'b0;
        repeat (n) @(posedge clk);
        #1 pause = 1'b1;
    endtask

    task automatic run_exp(input int n, input int which, input int val,
                           input bit ovf, input string name);
        run(n);
        push_exp(which, val, ovf, name);
    endtask

    task automatic clear();
        clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic read_frame(input int which, output int val,
                              output bit ovf, output bit ok);
        int         nd;
        int         idx;
        int         d;
        int         digs[8];
        bit         seen[8];
        logic [7:0] en;
        logic [6:0] sg;
        nd  = (which == 0) ? 4 : 2;
        ok  = 1'b1;
        val = 0;
        ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            digs[i] = 0;
            seen[i] = 1'b0;
        end
        for (int c = 0; c < nd * 4; c++) begin
            @(negedge clk);
            en  = (which == 0) ? uio_out : uio_out2;
            sg  = (which == 0) ? uo_out[6:0] : uo_out2[6:0];
            ovf = (which == 0) ? uo_out[7] : uo_out2[7];
            idx = -1;
            for (int i = 0; i < 8; i++)
                if (en == 8'(1 << i)) idx = i;
            if (idx < 0 || idx >= nd) begin
                ok = 1'b0;
            end else begin
                d = seg2dig(sg);
                if (d < 0) ok = 1'b0;
                else begin
                    digs[idx] = d;
                    seen[idx] = 1'b1;
                end
                if (which == 0) seg_seen[idx] = sg;
            end
        end
        for (int i = nd - 1; i >= 0; i--) begin
            if (!seen[i]) ok = 1'b0;
            val = val * 10 + digs[i];
        end
    endtask

    task automatic check_frame();
        exp_t e;
        int   v;
        bit   o;
        bit   ok;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got no entry, required one");
            return;
        end
        e = sbq.pop_front();
        read_frame(e.which, v, o, ok);
        checks++;
        if (!ok || v !== e.val) begin
            failures++;
            $display("FAIL %s value: got %0d (decode_ok=%0d) expected %0d",
                     e.name, v, ok, e.val);
        end
        checks++;
        if (o !== e.ovf) begin
            failures++;
            $display("FAIL %s ovf: got %0d expected %0d", e.name, o, e.ovf);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h3F) begin
            failures++;
            $display("FAIL reset_uo_out: got %h expected 3f", uo_out);
        end
        checks++;
        if (uio_out !== 8'h01) begin
            failures++;
            $display("FAIL reset_uio_out: got %h expected 01", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h0F) begin
            failures++;
            $display("FAIL reset_uio_oe: got %h expected 0f", uio_oe);
        end
        checks++;
        if (uio_oe2 !== 8'h03) begin
            failures++;
            $display("FAIL reset_uio_oe2: got %h expected 03", uio_oe2);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_exp(0, 0, 1'b0, "reset_frame");
        check_frame();
    endtask

    task automatic test_rate();
        rate = 5'd1;
        down = 1'b0;
        clear();
        run_exp(4096, 0, 0, 1'b0, "r1_pre_tick1");  check_frame();
        run_exp(1,    0, 1, 1'b0, "r1_tick1");      check_frame();
        run_exp(4096, 0, 1, 1'b0, "r1_pre_tick2");  check_frame();
        run_exp(1,    0, 2, 1'b0, "r1_tick2");      check_frame();
        run_exp(4097, 0, 3, 1'b0, "r1_tick3");      check_frame();
        rate = 5'd0;
        run_exp(70,   0, 10, 1'b0, "r0_to_10");     check_frame();
        checks++;
        if (seg_seen[1] !== 7'h06) begin
            failures++;
            $display("FAIL scan_digit1_seg: got %h expected 06", seg_seen[1]);
        end
        checks++;
        if (seg_seen[0] !== 7'h3F) begin
            failures++;
            $display("FAIL scan_digit0_seg: got %h expected 3f", seg_seen[0]);
        end
    endtask

    task automatic test_down();
        down = 1'b1;
        run_exp(10, 0, 9, 1'b0, "down_10_to_9");  check_frame();
        clear();
        run_exp(10, 0, 9999, 1'b1, "down_wrap");  check_frame();
    endtask

    task automatic test_up_wrap();
        down = 1'b0;
        run_exp(10, 0, 0, 1'b1, "up_wrap_9999");  check_frame();
        clear();
        push_exp(0, 0, 1'b0, "clear_ovf");        check_frame();
        run(990);
        push_exp(0, 99, 1'b0, "main_99");
        push_exp(1, 99, 1'b0, "d2_99");
        check_frame();
        check_frame();
        run(10);
        push_exp(0, 100, 1'b0, "main_100");
        push_exp(1, 0, 1'b1, "d2_up_wrap");
        check_frame();
        check_frame();
        clear();
        push_exp(1, 0, 1'b0, "d2_clear_ovf");     check_frame();
    endtask

    task automatic test_hold();
        logic [7:0] prev;
        logic [7:0] want;
        bit         found;
        int         bad;
        clear();
        run(25);
        repeat (50) @(posedge clk);
        #1 push_exp(0, 2, 1'b0, "pause_hold");    check_frame();
        run_exp(4, 0, 2, 1'b0, "pause_p_kept");   check_frame();
        run_exp(1, 0, 3, 1'b0, "pause_p_tick");   check_frame();
        ena   = 1'b0;
        pause = 1'b0;
        repeat (50) @(posedge clk);
        found = 1'b0;
        @(negedge clk);
        prev = uio_out;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (prev != 8'h01 && uio_out == 8'h01) found = 1'b1;
            else prev = uio_out;
        end
        bad = 0;
        if (found) begin
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                want = 8'(1 << ((i / 4) % 4));
                if (uio_out !== want) bad++;
            end
        end
        checks++;
        if (!found || bad != 0) begin
            failures++;
            $display("FAIL ena_low_scan: got found=%0d bad=%0d expected 1/0",
                     found, bad);
        end
        push_exp(0, 3, 1'b0, "ena_low_hold");     check_frame();
        ena   = 1'b1;
        pause = 1'b1;
        run_exp(9, 0, 3, 1'b0, "pre_clear_tick"); check_frame();
        pause = 1'b0;
        clr   = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        pause  = 1'b1;
        push_exp(0, 0, 1'b0, "clear_on_tick");    check_frame();
        run_exp(9, 0, 0, 1'b0, "clear_p_zero");   check_frame();
        run_exp(1, 0, 1, 1'b0, "clear_p_tick");   check_frame();
    endtask

    task automatic test_rate_drop();
        rate = 5'd2;
        clear();
        run_exp(5000, 0, 0, 1'b0, "r2_p5000");    check_frame();
        rate = 5'd1;
        run_exp(1,    0, 1, 1'b0, "drop_tick");   check_frame();
        run_exp(4096, 0, 1, 1'b0, "drop_pre");    check_frame();
        run_exp(1,    0, 2, 1'b0, "drop_period"); check_frame();
    endtask

    task automatic test_reset_mid();
        rate = 5'd0;
        clear();
        run_exp(4270, 0, 427, 1'b0, "pre_reset_427"); check_frame();
        pause = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'h3F) begin
            failures++;
            $display("FAIL midreset_uo_out: got %h expected 3f", uo_out);
        end
        checks++;
        if (uio_out !== 8'h01) begin
            failures++;
            $display("FAIL midreset_uio_out: got %h expected 01", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h0F) begin
            failures++;
            $display("FAIL midreset_uio_oe: got %h expected 0f", uio_oe);
        end
        pause = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        push_exp(0, 0, 1'b0, "post_reset");       check_frame();
        run_exp(9, 0, 0, 1'b0, "post_reset_pre"); check_frame();
        run_exp(1, 0, 1, 1'b0, "post_reset_tick"); check_frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_rate();
        test_down();
        test_up_wrap();
        test_hold();
        test_rate_drop();
        test_reset_mid();
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0",
                     sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
